gate_vector_sequencer: RTL and testbench

//  Synchronous stimulus/check stage wrapped around a 5-input combinational CMOS gate.

---
 rtl/gate_vector_sequencer.sv | 113 +++++++++++
 tb/tb_gate_vector_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gate_vector_sequencer.sv
// Vector sequencer and checker for a 5-input combinational gate cell.
// Optional feature: define SEQ_STOP_ON_FAIL_EN to end a run on its first mismatch.
module gate_vector_sequencer #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned VEC_FIRST   = 0,
  parameter int unsigned VEC_LAST    = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] expected,
  input  logic        f_in,
  output logic [4:0]  vec_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [5:0]  err_count,
  output logic [4:0]  fail_vec
);

  localparam int unsigned HOLD_W           = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [4:0] VEC_FIRST_V       = 5'(VEC_FIRST);
  localparam logic [4:0] VEC_LAST_V        = 5'(VEC_LAST);

  // Reject configurations that would hold a vector for zero cycles or run backwards.
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be at least 1");
  end
  if ((VEC_FIRST > VEC_LAST) || (VEC_LAST > 31)) begin : g_bad_range
    $error("vector range must satisfy VEC_FIRST <= VEC_LAST <= 31");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [31:0]         exp_q;
  logic [HOLD_W-1:0]   hold_cnt_q;

  logic                sample_c;
  logic                mismatch_c;
  logic                last_vec_c;
  logic                end_run_c;
  logic [5:0]          err_count_d;

  // Sample point is the last cycle of each vector's hold window.
  always_comb begin
    sample_c    = (state_q == S_RUN) && (hold_cnt_q == HOLD_LAST);
    mismatch_c  = sample_c && (f_in != exp_q[vec_out]);
    last_vec_c  = (vec_out == VEC_LAST_V);
    err_count_d = err_count + 6'(mismatch_c);
`ifdef SEQ_STOP_ON_FAIL_EN
    end_run_c   = last_vec_c || mismatch_c;
`else
    end_run_c   = last_vec_c;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      exp_q      <= '0;
      hold_cnt_q <= '0;
      vec_out    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_vec   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_RUN;
            exp_q      <= expected;
            vec_out    <= VEC_FIRST_V;
            hold_cnt_q <= '0;
            err_count  <= '0;
            fail_vec   <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
          end
        end
        S_RUN: begin
          if (sample_c) begin
            err_count <= err_count_d;
            if (mismatch_c && (err_count == 6'd0)) begin
              fail_vec <= vec_out;
            end
            if (end_run_c) begin
              state_q <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (err_count_d == 6'd0);
            end else begin
              vec_out    <= vec_out + 5'd1;
              hold_cnt_q <= '0;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Scoreboard bench for gate_vector_sequencer: default instance plus a single-vector, hold-1 instance.
module tb_gate_vector_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start2;
  logic [31:0] expected, expected2;
  logic        f_in, f_in2;
  logic [4:0]  vec_out, vec_out2;
  logic        busy, busy2, done, done2, pass, pass2;
  logic [5:0]  err_count, err_count2;
  logic [4:0]  fail_vec, fail_vec2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int entry_cyc;
  int gate_mode = 0;

  typedef struct {
    int err;
    int fvec;
    int pass;
    int vec;
    int lat;
  } result_t;

  result_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  gate_vector_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .expected(expected), .f_in(f_in),
    .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec)
  );

  gate_vector_sequencer #(.HOLD_CYCLES(1), .VEC_FIRST(8), .VEC_LAST(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .expected(expected2), .f_in(f_in2),
    .vec_out(vec_out2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err_count2), .fail_vec(fail_vec2)
  );

  function automatic logic gate_f(int mode, int v);
    logic [4:0] vv;
    vv = 5'(v);
    return (mode == 1) ? (&vv) : 1'b0;
  endfunction

  always_comb f_in  = gate_f(gate_mode, int'(vec_out));
  always_comb f_in2 = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic result_t model(int mode, logic [31:0] tbl, int first, int last, int hold);
    result_t r;
    bit stop;
    r.err = 0; r.fvec = 0; r.vec = last;
    r.lat = (last - first + 1) * hold;
    stop = 0;
    for (int v = first; v <= last; v++) begin
      if (!stop && (gate_f(mode, v) != tbl[v])) begin
        if (r.err == 0) r.fvec = v;
        r.err++;
`ifdef SEQ_STOP_ON_FAIL_EN
        stop  = 1;
        r.vec = v;
        r.lat = (v - first + 1) * hold;
`endif
      end
    end
    r.pass = (r.err == 0) ? 1 : 0;
    return r;
  endfunction

  task automatic start_run(input int which, input int mode, input logic [31:0] tbl);
    @(negedge clk);
    if (which == 0) begin
      gate_mode = mode;
      expected  = tbl;
      start     = 1'b1;
      sb.push_back(model(mode, tbl, 0, 31, 2));
    end else begin
      expected2 = tbl;
      start2    = 1'b1;
      sb.push_back(model(0, tbl, 8, 8, 1));
    end
    @(negedge clk);
    entry_cyc = cyc;
    start  = 1'b0;
    start2 = 1'b0;
    if (which == 0) check_eq("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_done(input int which, input string tag);
    result_t e;
    int n = 0;
    e = sb.pop_front();
    while (((which == 0) ? done : done2) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check_eq({tag, "_timeout"}, 0, 1);
    end else if (which == 0) begin
      check_eq({tag, "_latency"}, cyc - entry_cyc, e.lat);
      check_eq({tag, "_err_count"}, int'(err_count), e.err);
      check_eq({tag, "_fail_vec"}, int'(fail_vec), e.fvec);
      check_eq({tag, "_pass"}, int'(pass), e.pass);
      check_eq({tag, "_vec_out"}, int'(vec_out), e.vec);
      check_eq({tag, "_busy"}, int'(busy), 0);
    end else begin
      check_eq({tag, "_latency"}, cyc - entry_cyc, e.lat);
      check_eq({tag, "_err_count"}, int'(err_count2), e.err);
      check_eq({tag, "_fail_vec"}, int'(fail_vec2), e.fvec);
      check_eq({tag, "_pass"}, int'(pass2), e.pass);
      check_eq({tag, "_vec_out"}, int'(vec_out2), e.vec);
    end
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_vec_out"}, int'(vec_out), 0);
    check_eq({tag, "_busy"}, int'(busy), 0);
    check_eq({tag, "_done"}, int'(done), 0);
    check_eq({tag, "_pass"}, int'(pass), 0);
    check_eq({tag, "_err_count"}, int'(err_count), 0);
    check_eq({tag, "_fail_vec"}, int'(fail_vec), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    expected = '0; expected2 = '0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    // All-zero gate against all-zero table
    start_run(0, 0, 32'h0);
    wait_done(0, "t1");

    // AND gate with one corrupted table entry at vector 5
    start_run(0, 1, 32'h8000_0000 ^ (32'h1 << 5));
    wait_done(0, "t2");

    // Every vector mismatches
    start_run(0, 0, 32'hFFFF_FFFF);
    wait_done(0, "t3");

    // Reset in the middle of a run
    start_run(0, 0, 32'h0);
    void'(sb.pop_front());
    n = 0;
    while (vec_out != 5'd10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("t4_reach_vec10", int'(vec_out), 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cleared("t4_after_rst");
    start_run(0, 0, 32'h0);
    wait_done(0, "t4_rerun");

    // Start re-pulse and table change while busy are ignored
    start_run(0, 0, 32'h0);
    repeat (20) @(negedge clk);
    expected = 32'hFFFF_FFFF;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    check_eq("t5_still_busy", int'(busy), 1);
    wait_done(0, "t5");

    // Single-vector, single-cycle configuration
    start_run(1, 0, 32'h0);
    wait_done(1, "t6_pass");
    start_run(1, 0, 32'h0000_0100);
    wait_done(1, "t6_fail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
